ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock.
REQ-002 SHALL provide: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL provide: start_E  input  1  valid RV32M op held in the ID/EX register this cycle.
REQ-004 SHALL provide: MDOp_E  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL provide: SrcA_E  input  32  rs1 operand, already forwarded.
REQ-006 SHALL provide: SrcB_E  input  32  rs2 operand, already forwarded.
REQ-007 SHALL provide: flush_E  input  1  kill the in-flight op (branch/jump redirect).
REQ-008 SHALL provide: Busy_E  output  1  stall request to PC, IF/ID and ID/EX registers.
REQ-009 SHALL provide: Done_E  output  1  one-cycle pulse; MDResult_E valid.
REQ-010 SHALL provide: MDResult_E  output  32  result, forwarded to EX/MEM in place of the ALU result.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-012 IDLE: start_E=1 and flush_E=0 SHALL latch operands and op; go to MUL (op<4), to DONE (divide fast path, REQ-017/018), else to DIV.
REQ-013 Busy_E SHALL be combinational: 1 in IDLE when start_E & ~flush_E; 1 in MUL and DIV; 0 in DONE.
REQ-014 MUL: one cycle; SHALL register the 64-bit product (signed×signed for MULH, signed×unsigned for MULHSU, unsigned×unsigned for MULHU/MUL); go to DONE.
REQ-015 MUL result SHALL be product[31:0] for MUL, product[63:32] otherwise.
REQ-016 DIV: SHALL run exactly 32 restoring iterations on magnitudes (counter 0..31, one quotient bit per cycle); go to DONE after iteration 31.
REQ-017 Divisor 0 SHALL skip DIV: quotient 0xFFFFFFFF, remainder = SrcA_E.
REQ-018 DIV/REM with SrcA_E=0x80000000, SrcB_E=0xFFFFFFFF SHALL skip DIV: quotient 0x80000000, remainder 0.
REQ-019 Signed ops SHALL negate quotient when operand signs differ; remainder SHALL take the dividend's sign.
REQ-020 DONE: Done_E=1, MDResult_E valid; SHALL return to IDLE unconditionally; start_E SHALL be ignored (same instruction still in ID/EX).
REQ-021 Latency start->Done_E: MUL* 2 cycles; fast-path divide 1 cycle; normal divide 33 cycles.
REQ-022 flush_E=1 in any state SHALL force IDLE next cycle, suppress Done_E, and not start a new op that cycle.
REQ-023 MDResult_E SHALL hold its last value outside DONE; consumers qualify with Done_E.
REQ-024 start_E with MDOp_E changing while Busy_E=1 SHALL have no effect (operands latched).

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, counter 0, Busy_E=0, Done_E=0, MDResult_E=0, operand/product registers 0.
REQ-026 Reset mid-DIV/MUL SHALL abandon the op; no Done_E after release.
REQ-027 First op SHALL be accepted on the first rising edge with rst=1.

Structure
REQ-028 Package md_pkg SHALL hold the MDOp enum (funct3 encodings), FSM state enum, and DIV_ITERS=32.
REQ-029 Iterative divider datapath (remainder/quotient shift registers, counter) SHALL be sub-module md_divider_core; FSM, multiplier, sign fix-up stay in ex_muldiv_unit.

Verification
REQ-030 MUL 7×-3 (0x00000007, 0xFFFFFFFD) -> Busy_E 2 cycles, Done_E at +2, MDResult_E=0xFFFFFFEB.
REQ-031 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV -7/2 -> Done_E at +33, 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14.
REQ-033 DIVU 5/0 -> Done_E at +1, 0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF -> 0 at +1.
REQ-034 flush_E at DIV iteration 10 -> IDLE next cycle, Busy_E=0, no Done_E; next DIVU 9/3 -> 3.
REQ-035 rst low at DIV iteration 20 -> outputs 0 immediately; back-to-back MUL after release completes at +2.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_pkg
// Purpose  : Shared types and constants for the RV32M multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package md_pkg;

  // funct3 encodings of the RV32M opcodes
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  // Magnitude of a value that may be two's complement signed
  function automatic logic [31:0] abs_val(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_divider_core.sv
`default_nettype none
// ============================================================================
// Module   : md_divider_core
// Purpose  : Unsigned restoring divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module md_divider_core
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_clear,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_last,
  output logic [31:0] o_quot_nxt,
  output logic [31:0] o_rem_nxt
);

  logic [31:0]      r_rem;
  logic [31:0]      r_quot;
  logic [31:0]      r_dvs;
  logic [CNT_W-1:0] r_cnt;

  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_qbit;

  // Dividend bits shift out of the quotient register as quotient bits shift in
  assign w_shift    = {r_rem, r_quot[31]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[32];
  assign o_rem_nxt  = w_qbit ? w_diff[31:0] : w_shift[31:0];
  assign o_quot_nxt = {r_quot[30:0], w_qbit};
  assign o_last     = (r_cnt == CNT_W'(DIV_ITERS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_dvs  <= i_divisor;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
    end else if (i_step) begin
      r_rem  <= o_rem_nxt;
      r_quot <= o_quot_nxt;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : EX-stage RV32M unit: single-cycle multiply, iterative divide.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_E,
  input  logic [2:0]  MDOp_E,
  input  logic [31:0] SrcA_E,
  input  logic [31:0] SrcB_E,
  input  logic        flush_E,
  output logic        Busy_E,
  output logic        Done_E,
  output logic [31:0] MDResult_E
);

  md_state_e   r_state;
  md_state_e   w_state_nxt;
  md_op_e      r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_product;
  logic [31:0] r_result;
  logic        r_res_is_mul;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_accept;
  logic        w_in_signed;
  logic        w_div0;
  logic        w_ovf;
  logic        w_fast;
  logic [31:0] w_fast_result;
  logic        w_a_sgn;
  logic        w_b_sgn;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_product;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;
  logic        w_div_last;
  logic [31:0] w_quot_nxt;
  logic [31:0] w_rem_nxt;

  // Divide corner cases resolved straight from the ID/EX operands
  assign w_accept    = (r_state == ST_IDLE) && start_E && !flush_E;
  assign w_in_signed = ~MDOp_E[0];
  assign w_div0      = (SrcB_E == 32'd0);
  assign w_ovf       = w_in_signed && (SrcA_E == 32'h8000_0000) && (SrcB_E == 32'hFFFF_FFFF);
  assign w_fast      = MDOp_E[2] && (w_div0 || w_ovf);

  always_comb begin
    w_fast_result = 32'd0;
    if (w_div0)
      w_fast_result = MDOp_E[1] ? SrcA_E : 32'hFFFF_FFFF;
    else
      w_fast_result = MDOp_E[1] ? 32'd0 : 32'h8000_0000;
  end

  // Sign-extend to 64 bits; the low 64 bits of the product are then exact
  assign w_a_sgn   = (r_op == MD_MULH) || (r_op == MD_MULHSU);
  assign w_b_sgn   = (r_op == MD_MULH);
  assign w_a64     = {{32{w_a_sgn & r_a[31]}}, r_a};
  assign w_b64     = {{32{w_b_sgn & r_b[31]}}, r_b};
  assign w_product = w_a64 * w_b64;

  assign w_quot_fix = r_neg_q ? (~w_quot_nxt + 32'd1) : w_quot_nxt;
  assign w_rem_fix  = r_neg_r ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

  md_divider_core u_divider (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept && MDOp_E[2] && !w_fast),
    .i_step     ((r_state == ST_DIV) && !flush_E),
    .i_clear    (flush_E),
    .i_dividend (abs_val(SrcA_E, w_in_signed)),
    .i_divisor  (abs_val(SrcB_E, w_in_signed)),
    .o_last     (w_div_last),
    .o_quot_nxt (w_quot_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    Busy_E      = 1'b0;
    Done_E      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_E && !flush_E) begin
          Busy_E = 1'b1;
          if (!MDOp_E[2])
            w_state_nxt = ST_MUL;
          else if (w_fast)
            w_state_nxt = ST_DONE;
          else
            w_state_nxt = ST_DIV;
        end
      end
      ST_MUL: begin
        Busy_E      = 1'b1;
        w_state_nxt = flush_E ? ST_IDLE : ST_DONE;
      end
      ST_DIV: begin
        Busy_E = 1'b1;
        if (flush_E)
          w_state_nxt = ST_IDLE;
        else if (w_div_last)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // Same instruction is still in ID/EX here, so start_E is not looked at
        Done_E      = !flush_E;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= MD_MUL;
      r_a     <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_op    <= md_op_e'(MDOp_E);
      r_a     <= SrcA_E;
      r_b     <= SrcB_E;
      r_neg_q <= w_in_signed & (SrcA_E[31] ^ SrcB_E[31]);
      r_neg_r <= w_in_signed & SrcA_E[31];
    end
  end

  // Result registers only change on entry to DONE, so the output holds otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_product    <= '0;
      r_result     <= '0;
      r_res_is_mul <= 1'b0;
    end else if (w_state_nxt == ST_DONE) begin
      case (r_state)
        ST_IDLE: begin
          r_result     <= w_fast_result;
          r_res_is_mul <= 1'b0;
        end
        ST_MUL: begin
          r_product    <= w_product;
          r_res_is_mul <= 1'b1;
        end
        ST_DIV: begin
          r_result     <= r_op[1] ? w_rem_fix : w_quot_fix;
          r_res_is_mul <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    MDResult_E = r_result;
    if (r_res_is_mul)
      MDResult_E = (r_op == MD_MUL) ? r_product[31:0] : r_product[63:32];
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Self-checking bench for ex_muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start_E;
  logic [2:0]  MDOp_E;
  logic [31:0] SrcA_E;
  logic [31:0] SrcB_E;
  logic        flush_E;
  logic        Busy_E;
  logic        Done_E;
  logic [31:0] MDResult_E;

  int total = 0;
  int bad   = 0;

  ex_muldiv_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start_E    (start_E),
    .MDOp_E     (MDOp_E),
    .SrcA_E     (SrcA_E),
    .SrcB_E     (SrcB_E),
    .flush_E    (flush_E),
    .Busy_E     (Busy_E),
    .Done_E     (Done_E),
    .MDResult_E (MDResult_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RV32M semantics in plain arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    int          sa;
    int          sb;
    logic        ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called at a falling edge; issues one op, holds start_E while the unit
  // stalls (scrambling op/operands), and checks latency, result and hold.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    int          lat;
    int          k;
    logic        seen;
    er      = ref_result(op, a, b);
    lat     = ref_latency(op, a, b);
    start_E = 1'b1;
    flush_E = 1'b0;
    MDOp_E  = op;
    SrcA_E  = a;
    SrcB_E  = b;
    #1;
    check("busy_on_issue", {31'd0, Busy_E}, 32'd1);
    seen = 1'b0;
    k    = 0;
    while (!seen && k <= 40) begin
      @(negedge clk);
      k++;
      MDOp_E = 3'($urandom_range(0, 7));
      SrcA_E = $urandom;
      SrcB_E = $urandom;
      #1;
      if (Done_E) seen = 1'b1;
      else if (k < lat) check("busy_while_running", {31'd0, Busy_E}, 32'd1);
    end
    check("done_latency", k, lat);
    check("result", MDResult_E, er);
    check("busy_in_done", {31'd0, Busy_E}, 32'd0);
    start_E = 1'b0;
    @(negedge clk);
    #1;
    check("done_single_pulse", {31'd0, Done_E}, 32'd0);
    check("result_hold", MDResult_E, er);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst     = 1'b0;
    start_E = 1'b0;
    flush_E = 1'b0;
    MDOp_E  = 3'd0;
    SrcA_E  = 32'd0;
    SrcB_E  = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", {31'd0, Busy_E}, 32'd0);
    check("reset_done", {31'd0, Done_E}, 32'd0);
    check("reset_result", MDResult_E, 32'd0);

    // Release and issue on the same falling edge: first rising edge accepts
    @(negedge clk);
    rst = 1'b1;
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd7, 32'h1234_5678, 32'd0);
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush together with start in IDLE: nothing starts
    start_E = 1'b1;
    flush_E = 1'b1;
    MDOp_E  = 3'd0;
    #1;
    check("flush_idle_busy", {31'd0, Busy_E}, 32'd0);
    @(negedge clk);
    start_E = 1'b0;
    flush_E = 1'b0;
    pulses  = 0;
    repeat (4) begin
      #1;
      if (Done_E) pulses++;
      @(negedge clk);
    end
    check("flush_idle_no_done", pulses, 0);

    // Flush at divide iteration 10
    start_E = 1'b1;
    MDOp_E  = 3'd4;
    SrcA_E  = 32'd1000;
    SrcB_E  = 32'd7;
    repeat (11) @(negedge clk);
    flush_E = 1'b1;
    #1;
    check("flush_div_done", {31'd0, Done_E}, 32'd0);
    @(negedge clk);
    flush_E = 1'b0;
    start_E = 1'b0;
    #1;
    check("after_flush_busy", {31'd0, Busy_E}, 32'd0);
    pulses = 0;
    repeat (40) begin
      #1;
      if (Done_E) pulses++;
      @(negedge clk);
    end
    check("no_done_after_flush", pulses, 0);
    run_op(3'd5, 32'd9, 32'd3);

    // Reset at divide iteration 20
    start_E = 1'b1;
    MDOp_E  = 3'd5;
    SrcA_E  = 32'hDEAD_BEEF;
    SrcB_E  = 32'd13;
    repeat (21) @(negedge clk);
    rst     = 1'b0;
    start_E = 1'b0;
    #1;
    check("midreset_busy", {31'd0, Busy_E}, 32'd0);
    check("midreset_done", {31'd0, Done_E}, 32'd0);
    check("midreset_result", MDResult_E, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(3'd0, 32'd123, 32'd456);
    run_op(3'd1, 32'hFFFF_FFF0, 32'd3);

    // Randomised ops including the divide corner cases
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 20); end
        3: rb = 32'($signed(-$urandom_range(1, 50)));
        default: ;
      endcase
      run_op(rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
